// File: rtl/alu_pkg.sv
// Shared constants and request type for the time-shared ALU scheduler.
// Optional build macro ALU_ARB_FIXED_PRIO_EN (see rr_arb2) selects fixed priority.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_OP_SLL  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_OP_SLT  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_OP_OR   = 4'b0100;
    localparam logic [OP_W-1:0] ALU_OP_XOR  = 4'b0101;
    localparam logic [OP_W-1:0] ALU_OP_SRL  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_OP_SRA  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_OP_AND  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_OP_PASS = 4'b1001;

    typedef struct packed {
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [OP_W-1:0]   alu_op;
        logic              unsign;
    } alu_req_t;

    // Value presented to the ALU when nobody holds the grant.
    localparam alu_req_t ALU_REQ_IDLE = '{
        op_a:   {DATA_W{1'b0}},
        op_b:   {DATA_W{1'b0}},
        alu_op: ALU_OP_ADD,
        unsign: 1'b0
    };

    function automatic alu_req_t pack_req(
        input logic [DATA_W-1:0] op_a,
        input logic [DATA_W-1:0] op_b,
        input logic [OP_W-1:0]   alu_op,
        input logic              unsign
    );
        alu_req_t r;
        r.op_a   = op_a;
        r.op_b   = op_b;
        r.alu_op = alu_op;
        r.unsign = unsign;
        return r;
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Request, response and ALU-side signal bundle of the shared-ALU scheduler.
// Configuration macro ALU_ARB_FIXED_PRIO_EN does not change this bundle.
interface alu_share_arb_if;
    import alu_pkg::*;

    logic              i_req0_valid;
    logic              o_req0_ready;
    logic [DATA_W-1:0] i_req0_op_a;
    logic [DATA_W-1:0] i_req0_op_b;
    logic [OP_W-1:0]   i_req0_alu_op;
    logic              i_req0_unsign;

    logic              i_req1_valid;
    logic              o_req1_ready;
    logic [DATA_W-1:0] i_req1_op_a;
    logic [DATA_W-1:0] i_req1_op_b;
    logic [OP_W-1:0]   i_req1_alu_op;
    logic              i_req1_unsign;

    logic              o_rsp0_valid;
    logic              i_rsp0_ready;
    logic [DATA_W-1:0] o_rsp0_data;
    logic              o_rsp1_valid;
    logic              i_rsp1_ready;
    logic [DATA_W-1:0] o_rsp1_data;

    logic [DATA_W-1:0] o_alu_op_a;
    logic [DATA_W-1:0] o_alu_op_b;
    logic [OP_W-1:0]   o_alu_op;
    logic              o_alu_unsign;
    logic [DATA_W-1:0] i_alu_data;

    modport slave (
        input  i_req0_valid, i_req0_op_a, i_req0_op_b, i_req0_alu_op, i_req0_unsign,
        input  i_req1_valid, i_req1_op_a, i_req1_op_b, i_req1_alu_op, i_req1_unsign,
        input  i_rsp0_ready, i_rsp1_ready, i_alu_data,
        output o_req0_ready, o_req1_ready,
        output o_rsp0_valid, o_rsp0_data, o_rsp1_valid, o_rsp1_data,
        output o_alu_op_a, o_alu_op_b, o_alu_op, o_alu_unsign
    );

    modport master (
        output i_req0_valid, i_req0_op_a, i_req0_op_b, i_req0_alu_op, i_req0_unsign,
        output i_req1_valid, i_req1_op_a, i_req1_op_b, i_req1_alu_op, i_req1_unsign,
        output i_rsp0_ready, i_rsp1_ready, i_alu_data,
        input  o_req0_ready, o_req1_ready,
        input  o_rsp0_valid, o_rsp0_data, o_rsp1_valid, o_rsp1_data,
        input  o_alu_op_a, o_alu_op_b, o_alu_op, o_alu_unsign
    );

endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-input grant logic; round-robin on ties by default, or requester 0
// always first when ALU_ARB_FIXED_PRIO_EN is defined (no history kept).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic [1:0] grant_s;

`ifdef ALU_ARB_FIXED_PRIO_EN

    // Fixed priority: requester 0 wins every tie, requester 1 may starve.
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = 2'b01;
            default: grant_s = 2'b00;
        endcase
    end

`else

    logic last_grant_r;

    // Tie goes to whichever requester was not served last.
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11: begin
                if (last_grant_r) begin
                    grant_s = 2'b01;
                end else begin
                    grant_s = 2'b10;
                end
            end
            default: grant_s = 2'b00;
        endcase
    end

    // History only moves on cycles that actually grant; reset favours requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (grant_s[0]) begin
            last_grant_r <= 1'b0;
        end else if (grant_s[1]) begin
            last_grant_r <= 1'b1;
        end
    end

`endif

    assign grant = grant_s;

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one combinational ALU between the EX stage (0) and an aux unit (1).
// Tie-break policy is selected by ALU_ARB_FIXED_PRIO_EN inside rr_arb2.
module alu_share_arb
    import alu_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    alu_share_arb_if.slave   bus
);

    logic [1:0]        elig_s;
    logic [1:0]        arb_grant_s;
    logic [1:0]        grant_s;
    alu_req_t          req0_s;
    alu_req_t          req1_s;
    alu_req_t          alu_drv_s;
    logic              rsp0_valid_r;
    logic              rsp1_valid_r;
    logic [DATA_W-1:0] rsp0_data_r;
    logic [DATA_W-1:0] rsp1_data_r;

    // A full response slot only admits a new op if it drains this same cycle.
    always_comb begin
        elig_s    = 2'b00;
        elig_s[0] = bus.i_req0_valid & (~rsp0_valid_r | bus.i_rsp0_ready);
        elig_s[1] = bus.i_req1_valid & (~rsp1_valid_r | bus.i_rsp1_ready);
    end

    rr_arb2 u_arb (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .req   (elig_s),
        .grant (arb_grant_s)
    );

    // Grants are suppressed combinationally while reset is held.
    always_comb begin
        grant_s = 2'b00;
        if (i_rst_n) begin
            grant_s = arb_grant_s;
        end else begin
            grant_s = 2'b00;
        end
    end

    // Route the granted requester to the ALU; idle drive is a zero ADD.
    always_comb begin
        req0_s    = pack_req(bus.i_req0_op_a, bus.i_req0_op_b, bus.i_req0_alu_op, bus.i_req0_unsign);
        req1_s    = pack_req(bus.i_req1_op_a, bus.i_req1_op_b, bus.i_req1_alu_op, bus.i_req1_unsign);
        alu_drv_s = ALU_REQ_IDLE;
        case (grant_s)
            2'b01:   alu_drv_s = req0_s;
            2'b10:   alu_drv_s = req1_s;
            default: alu_drv_s = ALU_REQ_IDLE;
        endcase
    end

    assign bus.o_req0_ready = grant_s[0];
    assign bus.o_req1_ready = grant_s[1];
    assign bus.o_alu_op_a   = alu_drv_s.op_a;
    assign bus.o_alu_op_b   = alu_drv_s.op_b;
    assign bus.o_alu_op     = alu_drv_s.alu_op;
    assign bus.o_alu_unsign = alu_drv_s.unsign;

    // Response slot 0: a new result wins over a simultaneous drain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp0_valid_r <= 1'b0;
            rsp0_data_r  <= {DATA_W{1'b0}};
        end else if (grant_s[0]) begin
            rsp0_valid_r <= 1'b1;
            rsp0_data_r  <= bus.i_alu_data;
        end else if (bus.i_rsp0_ready) begin
            rsp0_valid_r <= 1'b0;
        end
    end

    // Response slot 1: same policy as slot 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp1_valid_r <= 1'b0;
            rsp1_data_r  <= {DATA_W{1'b0}};
        end else if (grant_s[1]) begin
            rsp1_valid_r <= 1'b1;
            rsp1_data_r  <= bus.i_alu_data;
        end else if (bus.i_rsp1_ready) begin
            rsp1_valid_r <= 1'b0;
        end
    end

    assign bus.o_rsp0_valid = rsp0_valid_r;
    assign bus.o_rsp0_data  = rsp0_data_r;
    assign bus.o_rsp1_valid = rsp1_valid_r;
    assign bus.o_rsp1_data  = rsp1_data_r;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb; honours ALU_ARB_FIXED_PRIO_EN in its grant model.
module tb_alu_share_arb;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arb_if bus ();

    alu_share_arb dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        mdl_last;
    logic        mdl_v0;
    logic        mdl_v1;
    logic [31:0] mdl_d0;
    logic [31:0] mdl_d1;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic u);
        case (op)
            ALU_OP_ADD:  return a + b;
            ALU_OP_SUB:  return a - b;
            ALU_OP_SLL:  return a << b[4:0];
            ALU_OP_SLT:  return u ? {31'd0, a < b} : {31'd0, $signed(a) < $signed(b)};
            ALU_OP_OR:   return a | b;
            ALU_OP_XOR:  return a ^ b;
            ALU_OP_SRL:  return a >> b[4:0];
            ALU_OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_OP_AND:  return a & b;
            ALU_OP_PASS: return b;
            default:     return 32'd0;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU.
    always_comb bus.i_alu_data = alu_ref(bus.o_alu_op, bus.o_alu_op_a, bus.o_alu_op_b, bus.o_alu_unsign);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        mdl_last = 1'b1;
        mdl_v0   = 1'b0;
        mdl_v1   = 1'b0;
        mdl_d0   = 32'd0;
        mdl_d1   = 32'd0;
        q0.delete();
        q1.delete();
    endtask

    // One clock cycle: drive, check combinational grant/ALU drive, then check registers.
    task automatic step(input logic v0, input alu_req_t r0, input logic v1, input alu_req_t r1,
                        input logic rr0, input logic rr1);
        logic     e0, e1, g0, g1;
        alu_req_t exp_drv;
        bus.i_req0_valid  = v0;
        bus.i_req0_op_a   = r0.op_a;
        bus.i_req0_op_b   = r0.op_b;
        bus.i_req0_alu_op = r0.alu_op;
        bus.i_req0_unsign = r0.unsign;
        bus.i_req1_valid  = v1;
        bus.i_req1_op_a   = r1.op_a;
        bus.i_req1_op_b   = r1.op_b;
        bus.i_req1_alu_op = r1.alu_op;
        bus.i_req1_unsign = r1.unsign;
        bus.i_rsp0_ready  = rr0;
        bus.i_rsp1_ready  = rr1;
        #2;
        e0 = v0 && (!mdl_v0 || rr0);
        e1 = v1 && (!mdl_v1 || rr1);
        g0 = e0;
        g1 = e1;
        if (e0 && e1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            g0 = 1'b1;
`else
            g0 = mdl_last;
`endif
            g1 = !g0;
        end
        exp_drv = g0 ? r0 : (g1 ? r1 : pack_req(32'd0, 32'd0, ALU_OP_ADD, 1'b0));
        check_val("ready0", 32'(bus.o_req0_ready), 32'(g0));
        check_val("ready1", 32'(bus.o_req1_ready), 32'(g1));
        check_val("alu_a", bus.o_alu_op_a, exp_drv.op_a);
        check_val("alu_b", bus.o_alu_op_b, exp_drv.op_b);
        check_val("alu_op", 32'(bus.o_alu_op), 32'(exp_drv.alu_op));
        check_val("alu_uns", 32'(bus.o_alu_unsign), 32'(exp_drv.unsign));
        if (g0) q0.push_back(alu_ref(r0.alu_op, r0.op_a, r0.op_b, r0.unsign));
        if (g1) q1.push_back(alu_ref(r1.alu_op, r1.op_a, r1.op_b, r1.unsign));
        @(posedge clk);
        #1;
        if (g0 && q0.size() > 0) begin
            mdl_v0 = 1'b1;
            mdl_d0 = q0.pop_front();
        end else if (rr0) begin
            mdl_v0 = 1'b0;
        end
        if (g1 && q1.size() > 0) begin
            mdl_v1 = 1'b1;
            mdl_d1 = q1.pop_front();
        end else if (rr1) begin
            mdl_v1 = 1'b0;
        end
        if (g0) mdl_last = 1'b0;
        else if (g1) mdl_last = 1'b1;
        check_val("rsp0_valid", 32'(bus.o_rsp0_valid), 32'(mdl_v0));
        check_val("rsp1_valid", 32'(bus.o_rsp1_valid), 32'(mdl_v1));
        check_val("rsp0_data", bus.o_rsp0_data, mdl_d0);
        check_val("rsp1_data", bus.o_rsp1_data, mdl_d1);
    endtask

    alu_req_t add_10_20, xor_aa_55, add_wrap, add_mix, sub_5_7, slt_s, slt_u, nop_r;

    initial begin
        add_10_20 = pack_req(32'd10, 32'd20, ALU_OP_ADD, 1'b0);
        xor_aa_55 = pack_req(32'hAAAAAAAA, 32'h55555555, ALU_OP_XOR, 1'b0);
        add_wrap  = pack_req(32'hFFFFFFFF, 32'h00000001, ALU_OP_ADD, 1'b0);
        add_mix   = pack_req(32'hFF010000, 32'hFFFFFF0F, ALU_OP_ADD, 1'b0);
        sub_5_7   = pack_req(32'd5, 32'd7, ALU_OP_SUB, 1'b0);
        slt_s     = pack_req(32'hFFFFFFFF, 32'h00000001, ALU_OP_SLT, 1'b0);
        slt_u     = pack_req(32'hFFFFFFFF, 32'h00000001, ALU_OP_SLT, 1'b1);
        nop_r     = pack_req(32'h12345678, 32'h9ABCDEF0, ALU_OP_OR, 1'b1);

        mdl_reset();
        bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
        bus.i_req0_op_a = 32'd0; bus.i_req0_op_b = 32'd0; bus.i_req0_alu_op = 4'd0; bus.i_req0_unsign = 1'b0;
        bus.i_req1_op_a = 32'd0; bus.i_req1_op_b = 32'd0; bus.i_req1_alu_op = 4'd0; bus.i_req1_unsign = 1'b0;
        bus.i_rsp0_ready = 1'b0; bus.i_rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rsp0_valid", 32'(bus.o_rsp0_valid), 32'd0);
        check_val("rst_rsp1_valid", 32'(bus.o_rsp1_valid), 32'd0);
        check_val("rst_rsp0_data", bus.o_rsp0_data, 32'd0);
        check_val("rst_rsp1_data", bus.o_rsp1_data, 32'd0);
        rst_n = 1'b1;

        // Ties from reset: round-robin 0,1,0,1 (or 0,0,0,0 with fixed priority).
        repeat (4) step(1'b1, add_10_20, 1'b1, xor_aa_55, 1'b1, 1'b1);
        // Requester 0 alone, then idle cycles with and without drain.
        step(1'b1, add_10_20, 1'b0, nop_r, 1'b1, 1'b1);
        step(1'b0, nop_r, 1'b0, nop_r, 1'b0, 1'b0);
        step(1'b0, nop_r, 1'b0, nop_r, 1'b1, 1'b1);
        // Wrap-around adds, operand order and unsigned flag routing.
        step(1'b1, add_wrap, 1'b1, add_mix, 1'b1, 1'b1);
        step(1'b1, add_mix, 1'b1, add_wrap, 1'b1, 1'b1);
        step(1'b1, sub_5_7, 1'b1, slt_u, 1'b1, 1'b1);
        step(1'b1, slt_s, 1'b1, sub_5_7, 1'b1, 1'b1);
        // Backpressure on slot 0: requester 1 gets through, then 0 refills with no gap.
        step(1'b0, nop_r, 1'b0, nop_r, 1'b1, 1'b1);
        step(1'b1, add_10_20, 1'b0, nop_r, 1'b0, 1'b1);
        step(1'b1, sub_5_7, 1'b1, xor_aa_55, 1'b0, 1'b1);
        step(1'b1, sub_5_7, 1'b1, add_wrap, 1'b1, 1'b1);
        step(1'b0, nop_r, 1'b1, add_mix, 1'b1, 1'b0);
        step(1'b0, nop_r, 1'b1, sub_5_7, 1'b1, 1'b0);
        step(1'b0, nop_r, 1'b0, nop_r, 1'b1, 1'b1);

        // Asynchronous reset right after requester 1 is accepted.
        step(1'b0, nop_r, 1'b1, xor_aa_55, 1'b1, 1'b1);
        bus.i_req0_valid = 1'b1;
        bus.i_req1_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_rsp1_valid", 32'(bus.o_rsp1_valid), 32'd0);
        check_val("mid_rst_rsp1_data", bus.o_rsp1_data, 32'd0);
        check_val("mid_rst_ready0", 32'(bus.o_req0_ready), 32'd0);
        check_val("mid_rst_ready1", 32'(bus.o_req1_ready), 32'd0);
        check_val("mid_rst_alu_op", 32'(bus.o_alu_op), 32'(ALU_OP_ADD));
        check_val("mid_rst_alu_a", bus.o_alu_op_a, 32'd0);
        @(posedge clk);
        #1;
        check_val("held_rst_rsp1_valid", 32'(bus.o_rsp1_valid), 32'd0);
        rst_n = 1'b1;
        mdl_reset();
        step(1'b1, add_10_20, 1'b1, xor_aa_55, 1'b1, 1'b1);
        step(1'b1, add_10_20, 1'b1, xor_aa_55, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
